// File: rtl/pipe_pkg.sv
// Shared width helpers and defaults for the pipeline drain FIFO slice.
// Pure declarations: no logic, no latency, no backpressure of its own.
package pipe_pkg;

  localparam int DATA_W    = 10;
  localparam int DEF_DEPTH = 8;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so a counter can hold the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

  typedef logic [cnt_w(DEF_DEPTH)-1:0] cnt_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port.
// Write lands on the clock edge, read is combinational from the address; no reset, no backpressure.
module fifo_mem_2p
  import pipe_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    clk_i,
  input  logic                    wr_en_i,
  input  logic [ptr_w(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]        wr_data_i,
  input  logic [ptr_w(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]        rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pipe_drain_fifo.sv
// Credit-granting FWFT buffer at the tail of a fixed-latency pipeline; words surface 1 cycle after arrival.
// Downstream stalls via out_ready; upstream is throttled by credit_out, which only counts pops a cycle late.
module pipe_drain_fifo
  import pipe_pkg::*;
#(
  parameter int WIDTH   = DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     issue_in,
  output logic                     credit_out,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     err_out
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic               err_q, err_d;
  logic [LATENCY-1:0] iss_hist_q, iss_hist_d;

  logic [CW:0] occupancy;
  logic        push, pop, iss, full, solicited, push_acc;

  always_comb begin
    occupancy  = {1'b0, count_q} + {1'b0, inflight_q};
    credit_out = occupancy < (CW+1)'(DEPTH);
    out_valid  = (count_q != '0);
    full       = (count_q == CW'(DEPTH));

    push      = in_valid;
    pop       = out_valid & out_ready;
    iss       = issue_in & credit_out;
    // A word with nothing outstanding is unsolicited and must not drive inflight below zero.
    solicited = push & (inflight_q != '0);
    push_acc  = push & (~full | pop);
  end

  always_comb begin
    wr_ptr_d   = push_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push_acc) - CW'(pop);
    inflight_d = inflight_q + CW'(iss) - CW'(solicited);
    err_d      = err_q
               | (issue_in & ~credit_out)
               | (push & ~solicited)
               | (push & ~push_acc);
    iss_hist_d = (iss_hist_q << 1) | LATENCY'(iss);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
      iss_hist_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      iss_hist_q <= iss_hist_d;
      // Pipeline contract: every granted issue shows up exactly LATENCY cycles later.
      if (iss_hist_q[LATENCY-1]) begin
        assert (in_valid);
      end
      assert (inflight_q <= CW'(DEPTH));
    end
  end

  assign count_out = count_q;
  assign err_out   = err_q;

  fifo_mem_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i     (clk_in),
    .wr_en_i   (push_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (in_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (out_data)
  );

endmodule

// File: tb/tb_pipe_drain_fifo.sv
// Randomized and directed bench for pipe_drain_fifo against a queue-based reference model.
module tb_pipe_drain_fifo;

  localparam int W = 10;
  localparam int D = 8;
  localparam int L = 1;

  logic         clk_in = 1'b0;
  logic         rst_in, issue_in, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         credit_out, out_valid, err_out;
  logic [W-1:0] out_data;
  logic [$clog2(D):0] count_out;

  pipe_drain_fifo #(.WIDTH(W), .DEPTH(D), .LATENCY(L)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .issue_in   (issue_in),
    .credit_out (credit_out),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .count_out  (count_out),
    .err_out    (err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic [W-1:0] dat; int due; } pw_t;

  pw_t          pq[$];       // words travelling through the upstream pipeline
  logic [W-1:0] fq[$];       // words the FIFO should hold, head first
  bit           err_m;
  int           cyc;
  logic [W-1:0] dut_log[$];
  int           dut_cyc[$];
  int           checks, failures;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit model_credit();
    return (fq.size() + pq.size()) < D;
  endfunction

  // One clock cycle: drive at the falling edge, compare against the model, advance the model.
  task automatic step(input bit iss_req, input logic [W-1:0] idat, input bit rdy,
                      input bit inj, input logic [W-1:0] jdat);
    bit deliver, vld, cm, full, pop;
    logic [W-1:0] ddat;
    deliver = (pq.size() > 0) && (pq[0].due == cyc);
    vld     = deliver || (inj && pq.size() == 0);
    ddat    = deliver ? pq[0].dat : jdat;
    issue_in  = iss_req;
    out_ready = rdy;
    in_valid  = vld;
    in_data   = vld ? ddat : W'($urandom);
    #1;
    cm = model_credit();
    check_eq("credit", credit_out, cm);
    check_eq("out_valid", out_valid, fq.size() != 0);
    if (fq.size() != 0) check_eq("out_data", out_data, fq[0]);
    check_eq("count", count_out, fq.size());
    check_eq("err", err_out, err_m);
    if (out_valid && out_ready) begin
      dut_log.push_back(out_data);
      dut_cyc.push_back(cyc);
    end
    if (iss_req && !cm) err_m = 1;
    full = (fq.size() == D);
    pop  = (fq.size() != 0) && rdy;
    if (deliver) void'(pq.pop_front());
    else if (vld) err_m = 1;
    if (pop) void'(fq.pop_front());
    if (vld) begin
      if (full && !pop) err_m = 1;
      else fq.push_back(ddat);
    end
    if (iss_req && cm) pq.push_back('{idat, cyc + L});
    @(posedge clk_in);
    cyc++;
    @(negedge clk_in);
  endtask

  task automatic do_reset(input int n);
    rst_in = 1; issue_in = 0; in_valid = 0; out_ready = 0; in_data = '0;
    repeat (n) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 0;
    pq.delete(); fq.delete(); err_m = 0;
  endtask

  task automatic fill_stalled(input logic [W-1:0] base, output int n);
    n = 0;
    while (credit_out && n < 20) begin
      step(1, base + W'(n), 0, 0, 0);
      n++;
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int n, pct;
    bit rdy;
    checks = 0; failures = 0; cyc = 0; err_m = 0;
    rst_in = 1; issue_in = 0; in_valid = 0; out_ready = 0; in_data = '0;
    @(negedge clk_in);
    do_reset(2);

    check_eq("rst_credit", credit_out, 1);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_count", count_out, 0);
    check_eq("rst_err", err_out, 0);

    // Latency: issue at cycle 0, pipeline delivers at 1, visible at 2.
    step(1, 10'h155, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check_eq("lat_valid", out_valid, 1);
    check_eq("lat_data", out_data, 10'h155);
    step(0, 0, 1, 0, 0);
    check_eq("lat_count", count_out, 0);

    // Fill while stalled, then drain in order.
    fill_stalled(10'h000, n);
    check_eq("fill_accepted", n, 8);
    check_eq("fill_count", count_out, 8);
    check_eq("fill_credit", credit_out, 0);
    check_eq("fill_err", err_out, 0);
    dut_log.delete(); dut_cyc.delete();
    repeat (10) step(0, 0, 1, 0, 0);
    check_eq("drain_n", dut_log.size(), 8);
    foreach (dut_log[i]) check_eq("drain_data", dut_log[i], i);

    // Streaming: one issue per cycle, consumer always ready.
    dut_log.delete(); dut_cyc.delete();
    for (int i = 0; i < 100; i++) begin
      check_eq("stream_cnt_le1", count_out <= 1, 1);
      step(1, W'(i), 1, 0, 0);
    end
    repeat (4) step(0, 0, 1, 0, 0);
    check_eq("stream_n", dut_log.size(), 100);
    foreach (dut_log[i]) check_eq("stream_data", dut_log[i], i);
    if (dut_cyc.size() == 100) check_eq("stream_gapless", dut_cyc[99] - dut_cyc[0], 99);

    // Push and pop together while full; the push can only be unsolicited here.
    do_reset(1);
    fill_stalled(10'h100, n);
    check_eq("pp_full", count_out, 8);
    step(0, 0, 1, 1, 10'h3AA);
    check_eq("pp_count", count_out, 8);
    check_eq("pp_head", out_data, 10'h101);
    check_eq("pp_err_unsolicited", err_out, 1);
    step(0, 0, 0, 1, 10'h2BB);
    check_eq("ovf_count", count_out, 8);
    check_eq("ovf_head", out_data, 10'h101);
    dut_log.delete(); dut_cyc.delete();
    repeat (10) step(0, 0, 1, 0, 0);
    check_eq("ovf_drain_n", dut_log.size(), 8);
    if (dut_log.size() == 8) check_eq("ovf_tail", dut_log[7], 10'h3AA);

    // Error 1: issue without credit; sticky until reset.
    do_reset(1);
    check_eq("e_rst_err", err_out, 0);
    fill_stalled(10'h040, n);
    step(1, 10'h3FF, 0, 0, 0);
    check_eq("e1_err", err_out, 1);
    repeat (3) step(0, 0, 0, 0, 0);
    check_eq("e1_sticky", err_out, 1);
    check_eq("e1_count", count_out, 8);
    do_reset(1);
    check_eq("e1_cleared", err_out, 0);

    // Error 2: unsolicited word is stored, inflight stays at zero.
    step(0, 0, 0, 1, 10'h055);
    check_eq("e2_err", err_out, 1);
    check_eq("e2_count", count_out, 1);
    check_eq("e2_credit", credit_out, 1);
    step(1, 10'h066, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_eq("e2_count2", count_out, 2);
    check_eq("e2_head", out_data, 10'h055);
    repeat (3) step(0, 0, 1, 0, 0);
    do_reset(1);

    // Random legal traffic under varying consumer throughput.
    for (int p = 0; p < 6; p++) begin
      pct = (p % 3 == 0) ? 20 : (p % 3 == 1) ? 60 : 95;
      for (int i = 0; i < 500; i++) begin
        rdy = ($urandom_range(0, 99) < pct);
        step(($urandom_range(0, 1) == 1) && model_credit(), W'($urandom), rdy, 0, 0);
      end
    end
    check_eq("rand_err", err_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
